// File: rtl/eq_menu_pkg.sv
//------------------------------------------------------------------------------
// Module      : eq_menu_pkg
// Description : Shared types and defaults for the equalizer menu controller
//               and the seven-segment decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package eq_menu_pkg;

    typedef enum logic [2:0] {
        ST_MENU        = 3'd0,
        ST_BAND_SEL    = 3'd1,
        ST_GAIN_EDIT   = 3'd2,
        ST_OFFSET_EDIT = 3'd3,
        ST_COMMIT      = 3'd4
    } eq_state_e;

    typedef enum logic [2:0] {
        MENU_EQ          = 3'd0,
        MENU_OFFSET      = 3'd1,
        MENU_RESET_GAINS = 3'd2
    } menu_item_e;

    typedef enum logic [2:0] {
        KEY_NONE   = 3'd0,
        KEY_BACK   = 3'd1,
        KEY_SELECT = 3'd2,
        KEY_UP     = 3'd3,
        KEY_DOWN   = 3'd4
    } key_e;

    localparam int c_NUM_BANDS    = 8;
    localparam int c_GAIN_W       = 4;
    localparam int c_GAIN_DEFAULT = 8;
    localparam int c_OFFSET_MAX   = 7;
    localparam int c_ACK_TIMEOUT  = 1024;
    localparam int c_BAND_W       = 3;
    localparam int c_OFFSET_W     = 3;

    // Simultaneous pulses resolve to a single key: back > select > up > down.
    function automatic key_e pick_key(input logic back, input logic sel,
                                      input logic up, input logic down);
        if (back)      return KEY_BACK;
        else if (sel)  return KEY_SELECT;
        else if (up)   return KEY_UP;
        else if (down) return KEY_DOWN;
        else           return KEY_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eq_menu_ctrl_sat_step.sv
//------------------------------------------------------------------------------
// Module      : sat_step
// Description : Combinational saturating +/-1 step, bounded to 0..MAX.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_step
    import eq_menu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    always_comb begin
        o_value = i_value;
        if (i_inc && (i_value < c_MAX)) begin
            o_value = i_value + 1'b1;
        end else if (i_dec && (i_value != '0)) begin
            o_value = i_value - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/eq_menu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : eq_menu_ctrl
// Description : Key-driven menu/parameter controller with req/ack commit of
//               equalizer gains and output offset to the DSP.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eq_menu_ctrl
    import eq_menu_pkg::*;
#(
    parameter int NUM_BANDS    = c_NUM_BANDS,
    parameter int GAIN_W       = c_GAIN_W,
    parameter int GAIN_DEFAULT = c_GAIN_DEFAULT,
    parameter int OFFSET_MAX   = c_OFFSET_MAX,
    parameter int ACK_TIMEOUT  = c_ACK_TIMEOUT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_select,
    input  logic                        i_back,
    input  logic                        i_up,
    input  logic                        i_down,
    input  logic                        i_load_ack,
    output logic [2:0]                  o_state,
    output logic [2:0]                  o_menu_state,
    output logic [2:0]                  o_band,
    output logic [NUM_BANDS*GAIN_W-1:0] o_gain,
    output logic [2:0]                  o_offset,
    output logic                        o_load_req,
    output logic                        o_err
);

    localparam int                    c_TIMER_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_BAND_W-1:0]   c_BAND_LAST  = c_BAND_W'(NUM_BANDS - 1);
    localparam logic [GAIN_W-1:0]     c_GAIN_RST   = GAIN_W'(GAIN_DEFAULT);
    localparam logic [c_TIMER_W-1:0]  c_TIMER_LAST = c_TIMER_W'(ACK_TIMEOUT - 1);

    eq_state_e                r_state, w_state_nxt;
    eq_state_e                r_ret_state, w_ret_nxt;
    menu_item_e               r_menu, w_menu_nxt;
    logic [c_BAND_W-1:0]      r_band, w_band_nxt;
    logic [GAIN_W-1:0]        r_gain [NUM_BANDS];
    logic [GAIN_W-1:0]        w_gain_nxt [NUM_BANDS];
    logic [GAIN_W-1:0]        r_shadow_gain, w_shadow_gain_nxt;
    logic [c_OFFSET_W-1:0]    r_offset, w_offset_nxt;
    logic [c_OFFSET_W-1:0]    r_shadow_offset, w_shadow_offset_nxt;
    logic                     r_load_req, w_load_req_nxt;
    logic                     r_err, w_err_nxt;
    logic [c_TIMER_W-1:0]     r_timer, w_timer_nxt;

    key_e                     w_key;
    logic                     w_inc;
    logic                     w_dec;
    logic [GAIN_W-1:0]        w_gain_step;
    logic [c_OFFSET_W-1:0]    w_offset_step;

    assign w_key = pick_key(i_back, i_select, i_up, i_down);
    assign w_inc = (w_key == KEY_UP);
    assign w_dec = (w_key == KEY_DOWN);

    sat_step #(
        .WIDTH (GAIN_W),
        .MAX   ((1 << GAIN_W) - 1)
    ) u_gain_step (
        .i_value (r_gain[r_band]),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_value (w_gain_step)
    );

    sat_step #(
        .WIDTH (c_OFFSET_W),
        .MAX   (OFFSET_MAX)
    ) u_offset_step (
        .i_value (r_offset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_value (w_offset_step)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_MENU;
            r_ret_state     <= ST_MENU;
            r_menu          <= MENU_EQ;
            r_band          <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_gain[b] <= c_GAIN_RST;
            end
            r_shadow_gain   <= c_GAIN_RST;
            r_offset        <= '0;
            r_shadow_offset <= '0;
            r_load_req      <= 1'b0;
            r_err           <= 1'b0;
            r_timer         <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_ret_state     <= w_ret_nxt;
            r_menu          <= w_menu_nxt;
            r_band          <= w_band_nxt;
            r_gain          <= w_gain_nxt;
            r_shadow_gain   <= w_shadow_gain_nxt;
            r_offset        <= w_offset_nxt;
            r_shadow_offset <= w_shadow_offset_nxt;
            r_load_req      <= w_load_req_nxt;
            r_err           <= w_err_nxt;
            r_timer         <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_ret_nxt           = r_ret_state;
        w_menu_nxt          = r_menu;
        w_band_nxt          = r_band;
        w_gain_nxt          = r_gain;
        w_shadow_gain_nxt   = r_shadow_gain;
        w_offset_nxt        = r_offset;
        w_shadow_offset_nxt = r_shadow_offset;
        w_load_req_nxt      = r_load_req;
        w_err_nxt           = r_err;
        w_timer_nxt         = r_timer;

        case (r_state)
            ST_MENU: begin
                case (w_key)
                    KEY_UP: begin
                        case (r_menu)
                            MENU_EQ:     w_menu_nxt = MENU_OFFSET;
                            MENU_OFFSET: w_menu_nxt = MENU_RESET_GAINS;
                            default:     w_menu_nxt = MENU_EQ;
                        endcase
                    end
                    KEY_DOWN: begin
                        case (r_menu)
                            MENU_EQ:     w_menu_nxt = MENU_RESET_GAINS;
                            MENU_OFFSET: w_menu_nxt = MENU_EQ;
                            default:     w_menu_nxt = MENU_OFFSET;
                        endcase
                    end
                    KEY_SELECT: begin
                        case (r_menu)
                            MENU_EQ: w_state_nxt = ST_BAND_SEL;
                            MENU_OFFSET: begin
                                w_shadow_offset_nxt = r_offset;
                                w_state_nxt         = ST_OFFSET_EDIT;
                            end
                            default: begin
                                for (int b = 0; b < NUM_BANDS; b++) begin
                                    w_gain_nxt[b] = c_GAIN_RST;
                                end
                                w_ret_nxt      = ST_MENU;
                                w_state_nxt    = ST_COMMIT;
                                w_load_req_nxt = 1'b1;
                                w_timer_nxt    = '0;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            ST_BAND_SEL: begin
                case (w_key)
                    KEY_BACK: w_state_nxt = ST_MENU;
                    KEY_SELECT: begin
                        w_shadow_gain_nxt = r_gain[r_band];
                        w_state_nxt       = ST_GAIN_EDIT;
                    end
                    KEY_UP:   w_band_nxt = (r_band == c_BAND_LAST) ? '0 : r_band + 1'b1;
                    KEY_DOWN: w_band_nxt = (r_band == '0) ? c_BAND_LAST : r_band - 1'b1;
                    default: ;
                endcase
            end

            ST_GAIN_EDIT: begin
                case (w_key)
                    KEY_BACK: begin
                        w_gain_nxt[r_band] = r_shadow_gain;
                        w_state_nxt        = ST_BAND_SEL;
                    end
                    KEY_SELECT: begin
                        w_ret_nxt      = ST_BAND_SEL;
                        w_state_nxt    = ST_COMMIT;
                        w_load_req_nxt = 1'b1;
                        w_timer_nxt    = '0;
                    end
                    KEY_UP, KEY_DOWN: w_gain_nxt[r_band] = w_gain_step;
                    default: ;
                endcase
            end

            ST_OFFSET_EDIT: begin
                case (w_key)
                    KEY_BACK: begin
                        w_offset_nxt = r_shadow_offset;
                        w_state_nxt  = ST_MENU;
                    end
                    KEY_SELECT: begin
                        w_ret_nxt      = ST_MENU;
                        w_state_nxt    = ST_COMMIT;
                        w_load_req_nxt = 1'b1;
                        w_timer_nxt    = '0;
                    end
                    KEY_UP, KEY_DOWN: w_offset_nxt = w_offset_step;
                    default: ;
                endcase
            end

            ST_COMMIT: begin
                // Ack wins over a timeout landing on the same edge.
                if (i_load_ack) begin
                    w_load_req_nxt = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = r_ret_state;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_load_req_nxt = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_timer_nxt    = '0;
                    w_state_nxt    = r_ret_state;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            default: w_state_nxt = ST_MENU;
        endcase
    end

    assign o_state      = r_state;
    assign o_menu_state = r_menu;
    assign o_band       = r_band;
    assign o_offset     = r_offset;
    assign o_load_req   = r_load_req;
    assign o_err        = r_err;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_gain_pack
        assign o_gain[b*GAIN_W +: GAIN_W] = r_gain[b];
    end

endmodule

`default_nettype wire

// File: tb/tb_eq_menu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_eq_menu_ctrl
// Description : Directed and randomized self-checking bench for eq_menu_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_eq_menu_ctrl;

    localparam int NB = 8;
    localparam int GW = 4;
    localparam int TO = 1024;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              sel  = 1'b0;
    logic              back = 1'b0;
    logic              up   = 1'b0;
    logic              down = 1'b0;
    logic              ack  = 1'b0;
    logic [2:0]        o_state;
    logic [2:0]        o_menu_state;
    logic [2:0]        o_band;
    logic [NB*GW-1:0]  o_gain;
    logic [2:0]        o_offset;
    logic              o_load_req;
    logic              o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integers, menu rules applied once per clock edge.
    int m_state, m_ret, m_menu, m_band, m_offset, m_req, m_err, m_wait, m_shadow;
    int m_gain [NB];

    eq_menu_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_select     (sel),
        .i_back       (back),
        .i_up         (up),
        .i_down       (down),
        .i_load_ack   (ack),
        .o_state      (o_state),
        .o_menu_state (o_menu_state),
        .o_band       (o_band),
        .o_gain       (o_gain),
        .o_offset     (o_offset),
        .o_load_req   (o_load_req),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NB*GW-1:0] exp_gain();
        logic [NB*GW-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i*GW +: GW] = GW'(m_gain[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ret = 0; m_menu = 0; m_band = 0; m_offset = 0;
        m_req = 0; m_err = 0; m_wait = 0; m_shadow = 0;
        for (int i = 0; i < NB; i++) m_gain[i] = 8;
    endtask

    task automatic enter_commit(input int ret);
        m_state = 4; m_ret = ret; m_req = 1; m_wait = 0;
    endtask

    task automatic model_step(input bit s, input bit b, input bit u, input bit d, input bit a);
        int k;
        if (m_state == 4) begin
            if (a) begin
                m_req = 0; m_err = 0; m_state = m_ret;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_req = 0; m_err = 1; m_state = m_ret;
                end
            end
            return;
        end
        k = b ? 1 : s ? 2 : u ? 3 : d ? 4 : 0;
        case (m_state)
            0: begin
                if (k == 3) m_menu = (m_menu + 1) % 3;
                else if (k == 4) m_menu = (m_menu + 2) % 3;
                else if (k == 2) begin
                    if (m_menu == 0) m_state = 1;
                    else if (m_menu == 1) begin m_shadow = m_offset; m_state = 3; end
                    else begin
                        for (int i = 0; i < NB; i++) m_gain[i] = 8;
                        enter_commit(0);
                    end
                end
            end
            1: begin
                if (k == 1) m_state = 0;
                else if (k == 2) begin m_shadow = m_gain[m_band]; m_state = 2; end
                else if (k == 3) m_band = (m_band + 1) % NB;
                else if (k == 4) m_band = (m_band + NB - 1) % NB;
            end
            2: begin
                if (k == 1) begin m_gain[m_band] = m_shadow; m_state = 1; end
                else if (k == 2) enter_commit(1);
                else if (k == 3 && m_gain[m_band] < 15) m_gain[m_band]++;
                else if (k == 4 && m_gain[m_band] > 0) m_gain[m_band]--;
            end
            3: begin
                if (k == 1) begin m_offset = m_shadow; m_state = 0; end
                else if (k == 2) enter_commit(0);
                else if (k == 3 && m_offset < 7) m_offset++;
                else if (k == 4 && m_offset > 0) m_offset--;
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check_val("state",  o_state,      m_state);
        check_val("menu",   o_menu_state, m_menu);
        check_val("band",   o_band,       m_band);
        check_val("gain",   o_gain,       exp_gain());
        check_val("offset", o_offset,     m_offset);
        check_val("req",    o_load_req,   m_req);
        check_val("err",    o_err,        m_err);
    endtask

    task automatic cycle(input bit s, input bit b, input bit u, input bit d, input bit a);
        sel = s; back = b; up = u; down = d; ack = a;
        @(posedge clk);
        model_step(s, b, u, d, a);
        #1;
        check_all();
        sel = 0; back = 0; up = 0; down = 0; ack = 0;
    endtask

    task automatic k_sel();  cycle(1, 0, 0, 0, 0); endtask
    task automatic k_back(); cycle(0, 1, 0, 0, 0); endtask
    task automatic k_up();   cycle(0, 0, 1, 0, 0); endtask
    task automatic k_down(); cycle(0, 0, 0, 1, 0); endtask
    task automatic k_idle(); cycle(0, 0, 0, 0, 0); endtask
    task automatic k_ack();  cycle(0, 0, 0, 0, 1); endtask

    initial begin
        int n_hi;
        model_reset();
        #12;
        check_all();
        rst = 0;

        // Menu wrap-around.
        k_up(); k_up(); k_up();
        check_val("menu_wrap", o_menu_state, 3'd0);

        // Band 7 gain saturation and acked commit.
        k_sel(); k_down();
        check_val("band_wrap_down", o_band, 3'd7);
        k_sel();
        repeat (10) k_up();
        check_val("gain_sat_hi", o_gain[31:28], 4'hF);
        k_sel();
        check_val("req_rise", o_load_req, 1'b1);
        repeat (4) k_idle();
        k_ack();
        check_val("req_fall_ack", o_load_req, 1'b0);
        check_val("ret_band_sel", o_state, 3'd1);

        // Cancelled edit on band 2 restores the shadow value.
        k_up(); k_up(); k_up();
        k_sel();
        k_up(); k_up(); k_up();
        k_back();
        check_val("gain_restore", o_gain[11:8], 4'h8);

        // back beats select in the same cycle.
        cycle(1, 1, 0, 0, 0);
        check_val("back_wins", o_state, 3'd0);

        // Commit with no ack times out after exactly TO cycles of request.
        k_sel(); k_sel(); k_down(); k_sel();
        n_hi = 0;
        while (o_load_req && n_hi < 2 * TO) begin
            n_hi++;
            k_idle();
        end
        check_val("timeout_len", n_hi, TO);
        check_val("timeout_err", o_err, 1'b1);
        k_sel(); k_down(); k_sel(); k_ack();
        check_val("err_cleared", o_err, 1'b0);
        k_back();

        // Offset saturates high, then commits.
        k_up(); k_sel();
        repeat (9) k_up();
        check_val("offset_sat_hi", o_offset, 3'd7);
        k_sel(); k_idle(); k_ack();

        // Reset gains, then asynchronous reset in the middle of the commit.
        k_up(); k_sel();
        check_val("reset_gains", o_gain, 32'h88888888);
        check_val("reset_gains_req", o_load_req, 1'b1);
        #2 rst = 1;
        #1;
        model_reset();
        check_val("arst_req", o_load_req, 1'b0);
        check_val("arst_state", o_state, 3'd0);
        check_val("arst_menu", o_menu_state, 3'd0);
        check_val("arst_offset", o_offset, 3'd0);
        check_all();
        #3 rst = 0;

        // Randomized key traffic, including colliding pulses and stray acks.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
